node_port_arbiter: RTL and testbench
====================================

// Module: node_port_arbiter
// PURPOSE
//   Round-robin arbiter that shares the single input of one processing node among its
//   four neighbour ports (A, B, C, D).
//   Accepts one 4-bit word from a winning requester and holds it on the node-side
//   interface until the node takes it. Flags a sticky stall error if the node never takes it.
//   Sits between the neighbour links and the node input inside each processor tile.
// PARAMETERS
//   DATA_W        4    width of a port word
//   TIMEOUT_CYC   255  node_ready-low cycles in OFFER before stall_err sets; 0 = check disabled
//   CNT_W         8    width of the stall counter; TIMEOUT_CYC must fit in CNT_W bits
// PORTS
//   clk        in   1         clock, all logic on posedge
//   reset      in   1         synchronous, active-high
//   en         in   1         1 = new grants allowed; 0 = no new grants (an OFFER still completes)
//   req_valid  in   4         per-port request, bit0=A, bit1=B, bit2=C, bit3=D
//   req_data   in   4*DATA_W  port words, port i at [i*DATA_W +: DATA_W]
//   req_ready  out  4         one-hot accept, combinational, only in IDLE
//   node_valid out  1         word offered to node
//   node_data  out  DATA_W    offered word, registered
//   node_src   out  2         index of the port that supplied node_data
//   node_ready in   1         node accepts the offered word
//   stall_err  out  1         sticky: node stalled TIMEOUT_CYC cycles
//   busy       out  1         1 while in OFFER
// BEHAVIOUR
//   Reset (sync, high) forces the following state:
//     - state=IDLE, rr_ptr=0, node_valid=0, node_data=0, node_src=0,
//       stall_cnt=0, stall_err=0, busy=0.
//     - req_ready=0 during reset.
//     - Reset mid-OFFER drops the held word silently.
//   FSM has 2 states: IDLE and OFFER.
//   IDLE:
//     - If en=1 and req_valid!=0, the winner is the first set bit scanning
//       rr_ptr, rr_ptr+1, ... (mod 4).
//     - req_ready is one-hot for the winner in the same cycle; it is 0 otherwise.
//     - At the edge: node_data<=winner word, node_src<=winner, stall_cnt<=0, state<=OFFER.
//     - Latency: node_valid goes high 1 cycle after the req handshake.
//   OFFER:
//     - node_valid=1; node_data and node_src are stable; req_ready=0.
//     - node_ready=1 -> transfer done. At the edge: state<=IDLE and rr_ptr<=node_src+1 (2-bit wrap, 3->0).
//     - node_ready=0 -> stall_cnt increments, saturating at all-ones.
//     - When TIMEOUT_CYC!=0 and stall_cnt==TIMEOUT_CYC-1 with node_ready=0, stall_err<=1.
//     - stall_err clears only on reset. The error does not abort the OFFER.
//   Throughput: at most one word per 2 cycles, because IDLE is always visited between words.
//   Fairness: a port that has just won has lowest priority next; a continuously requesting
//     port waits at most 3 grants.
//   Boundary cases:
//     - en drop during OFFER: the OFFER completes normally.
//     - req_valid deasserted during OFFER: no effect, the word is already captured.
//     - Simultaneous requests: resolved purely by rr_ptr order.
//     - node_ready high while in IDLE: ignored.
//   busy = (state==OFFER). Requesters must hold req_valid and req_data stable until req_ready.
// TESTING
//   1. Reset, then A valid data=0x5, node_ready=1 -> req_ready=0001 in cycle 0;
//      node_valid, node_data=5, node_src=0 in cycle 1; rr_ptr=1 after.
//   2. All four ports valid continuously, node_ready=1 -> grant order A,B,C,D,A;
//      one word every 2 cycles.
//   3. rr_ptr=3, requests B and D -> D wins; then rr_ptr=0 and B wins next.
//   4. TIMEOUT_CYC=4, node_ready held 0 in OFFER -> stall_err rises after the 4th stall cycle;
//      data held; node_ready=1 completes the transfer; stall_err stays 1.
//   5. en=0 with A valid -> req_ready=0000, node_valid=0; en=1 -> A granted next cycle.
//   6. reset asserted mid-OFFER -> next cycle node_valid=0, rr_ptr=0, stall_err=0, state IDLE.

Source files
------------

// File: rtl/node_port_arbiter_if.sv
// Neighbour-port request bus and node-side offer bus of the node port arbiter.
// The arbiter uses the slave modport; whatever drives the ports and the node uses master.
interface node_port_arbiter_if #(
  parameter int DATA_W = 4
);
  logic                  en;
  logic [3:0]            req_valid;
  logic [4*DATA_W-1:0]   req_data;
  logic [3:0]            req_ready;
  logic                  node_valid;
  logic [DATA_W-1:0]     node_data;
  logic [1:0]            node_src;
  logic                  node_ready;
  logic                  stall_err;
  logic                  busy;

  modport slave (
    input  en, req_valid, req_data, node_ready,
    output req_ready, node_valid, node_data, node_src, stall_err, busy
  );

  modport master (
    output en, req_valid, req_data, node_ready,
    input  req_ready, node_valid, node_data, node_src, stall_err, busy
  );
endinterface

// File: rtl/node_port_arbiter.sv
// Round-robin arbiter sharing one node input among four neighbour ports (A..D),
// holding the granted word until the node takes it and flagging a sticky stall error.
//
// state | meaning
// IDLE  | no word held; may grant a requester when en=1
// OFFER | word held on node side until node_ready
module node_port_arbiter #(
  parameter int DATA_W      = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  node_port_arbiter_if.slave   bus_io
);

  typedef enum logic {IDLE, OFFER} state_e;

  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [1:0]          rr_q;
  logic [1:0]          node_src_q;
  logic [DATA_W-1:0]   node_data_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic                stall_err_q;

  logic                win_vld;
  logic [1:0]          win_idx;
  logic                grant;
  logic                xfer;
  logic                stall_hit;

  // Scan from the highest offset down so the nearest set bit after rr_q wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_q;
    for (int k = 3; k >= 0; k--) begin
      if (bus_io.req_valid[rr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = rr_q + 2'(k);
      end
    end
  end

  assign grant     = (state_q == IDLE) && bus_io.en && win_vld && !reset;
  assign xfer      = (state_q == OFFER) && bus_io.node_ready;
  assign stall_hit = (TIMEOUT_CYC != 0) && (state_q == OFFER) && !bus_io.node_ready
                     && (stall_cnt_q == STALL_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = OFFER;
      OFFER:   if (bus_io.node_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_io.req_ready  = grant ? (4'b0001 << win_idx) : 4'b0000;
    bus_io.node_valid = (state_q == OFFER);
    bus_io.busy       = (state_q == OFFER);
    bus_io.node_data  = node_data_q;
    bus_io.node_src   = node_src_q;
    bus_io.stall_err  = stall_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q        <= 2'd0;
      node_src_q  <= 2'd0;
      node_data_q <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      if (grant) begin
        node_data_q <= bus_io.req_data[win_idx*DATA_W +: DATA_W];
        node_src_q  <= win_idx;
        stall_cnt_q <= '0;
      end else if ((state_q == OFFER) && !bus_io.node_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      // The port just served drops to lowest priority.
      if (xfer) rr_q <= node_src_q + 2'd1;
      if (stall_hit) stall_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_node_port_arbiter.sv
// Self-checking bench for node_port_arbiter: per-cycle vector table plus hand-written
// stall and mid-offer reset sequences, with a scoreboard of granted words.
module tb_node_port_arbiter;

  logic clk;
  logic reset;

  node_port_arbiter_if #(.DATA_W(4)) bus();

  node_port_arbiter #(.DATA_W(4), .TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] rv;
    logic       nr;
    logic [3:0] ready;
    logic       nv;
    logic [3:0] nd;
    logic [1:0] ns;
    logic       busy;
    logic       err;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] req_words = 16'hC3A5;  // D=C, C=3, B=A, A=5
  logic [5:0]  sbq[$];
  vec_t        tbl[24];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [5:0] got;
    logic [5:0] want;
    @(posedge clk);
    #1;
    reset          = v.rst;
    bus.en         = v.en;
    bus.req_valid  = v.rv;
    bus.node_ready = v.nr;
    if (v.rst) sbq.delete();
    for (int k = 0; k < 4; k++)
      if (v.ready[k]) sbq.push_back({req_words[k*4 +: 4], 2'(k)});
    @(negedge clk);
    chk({tag, " req_ready"},  8'(bus.req_ready),  8'(v.ready));
    chk({tag, " node_valid"}, 8'(bus.node_valid), 8'(v.nv));
    chk({tag, " node_data"},  8'(bus.node_data),  8'(v.nd));
    chk({tag, " node_src"},   8'(bus.node_src),   8'(v.ns));
    chk({tag, " busy"},       8'(bus.busy),       8'(v.busy));
    chk({tag, " stall_err"},  8'(bus.stall_err),  8'(v.err));
    if (bus.node_valid && bus.node_ready && !v.rst) begin
      got = {bus.node_data, bus.node_src};
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s sb: got %0h expected none", tag, got);
      end else begin
        want = sbq.pop_front();
        chk({tag, " sb"}, 8'(got), 8'(want));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.en         = 1'b0;
    bus.req_valid  = 4'h0;
    bus.req_data   = req_words;
    bus.node_ready = 1'b0;

    //           rst   en    rv     nr    ready  nv    nd     ns     busy  err
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h1, 1'b1, 4'h1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 4'h5, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h2, 1'b0, 4'h5, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 4'hA, 2'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h4, 1'b0, 4'hA, 2'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 4'h3, 2'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h8, 1'b0, 4'h3, 2'd2, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 4'hC, 2'd3, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h1, 1'b0, 4'hC, 2'd3, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 4'h5, 2'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h2, 1'b0, 4'h5, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 4'hA, 2'd1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'h4, 1'b1, 4'h4, 1'b0, 4'hA, 2'd1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 4'h3, 2'd2, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 4'hA, 1'b1, 4'h8, 1'b0, 4'h3, 2'd2, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 4'hA, 1'b1, 4'h0, 1'b1, 4'hC, 2'd3, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 4'hA, 1'b1, 4'h2, 1'b0, 4'hC, 2'd3, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 4'hA, 2'd1, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 4'h1, 1'b1, 4'h0, 1'b0, 4'hA, 2'd1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 4'h1, 1'b1, 4'h0, 1'b0, 4'hA, 2'd1, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 4'h1, 1'b1, 4'h1, 1'b0, 4'hA, 2'd1, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 4'h5, 2'd0, 1'b1, 1'b0};

    for (int i = 0; i < 24; i++) run_vec(tbl[i], $sformatf("row%0d", i));

    // Stall: B granted, node holds off; the error sets after the 4th stall cycle.
    run_vec('{1'b0, 1'b1, 4'h2, 1'b0, 4'h2, 1'b0, 4'h5, 2'd0, 1'b0, 1'b0}, "stall_grant");
    for (int i = 1; i <= 4; i++)
      run_vec('{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 4'hA, 2'd1, 1'b1, 1'b0},
              $sformatf("stall_cyc%0d", i));
    run_vec('{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 4'hA, 2'd1, 1'b1, 1'b1}, "stall_set");
    run_vec('{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 4'hA, 2'd1, 1'b1, 1'b1}, "stall_take");
    run_vec('{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'hA, 2'd1, 1'b0, 1'b1}, "stall_sticky");

    // Reset mid-OFFER drops the word and returns to the reset state.
    run_vec('{1'b0, 1'b1, 4'h4, 1'b0, 4'h4, 1'b0, 4'hA, 2'd1, 1'b0, 1'b1}, "rst_grant");
    run_vec('{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 4'h3, 2'd2, 1'b1, 1'b1}, "rst_assert");
    run_vec('{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0}, "rst_after");
    run_vec('{1'b0, 1'b1, 4'hF, 1'b1, 4'h1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0}, "rst_rr0");
    run_vec('{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 4'h5, 2'd0, 1'b1, 1'b0}, "rst_offer");

    chk("sb_empty", 8'(sbq.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
